// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared constants and state type for the round-robin grant generator
package rr_grant_pkg;

  localparam int N_REQ  = 8;
  localparam int PTR_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_grant_gen_if.sv
// rtl/rr_grant_gen_if.sv - request/grant bundle between requesters and the grant generator
interface rr_grant_gen_if;
  import rr_grant_pkg::*;

  logic [N_REQ-1:0] req;
  logic             ack;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic             enc_dis;
  logic             timeout;

  // requester / consumer side
  modport master (
    output req,
    output ack,
    input  gnt,
    input  gnt_valid,
    input  enc_dis,
    input  timeout
  );

  // grant generator side
  modport slave (
    input  req,
    input  ack,
    output gnt,
    output gnt_valid,
    output enc_dis,
    output timeout
  );

endinterface

// File: rtl/rr_grant_gen_pick.sv
// rtl/rr_grant_gen_pick.sv - combinational rotating-priority winner select starting at ptr
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  logic [PTR_W-1:0] idx;

  // scan from farthest to nearest offset so the nearest requester at or above ptr wins
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_gen.sv
// rtl/rr_grant_gen.sv - round-robin one-hot grant FSM; optional hold timeout under RR_GRANT_TIMEOUT_EN
module rr_grant_gen
  import rr_grant_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst,
  rr_grant_gen_if.slave bus
);

  // an out-of-range timeout refuses to elaborate
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    rr_grant_gen_illegal_timeout_cycles u_bad ();
  end

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             timeout_q, timeout_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(TIMEOUT_CYCLES);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  rr_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  // next-state, next-grant and pointer advance
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          state_d = GRANT;
          win_d   = pick_idx;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (bus.ack) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = win_q + PTR_W'(1);
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (hold_q + HOLD_W'(1) == HOLD_LIMIT) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = win_q + PTR_W'(1);
          timeout_d = 1'b1;
          hold_d    = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // state register; reset overrides any ack or request on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.enc_dis   = ~(|gnt_q);
`ifdef RR_GRANT_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
